// File: rtl/lsu_mem_master_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_master_if
// Purpose : Bundles the core-side request/response handshake and the
//           data-memory strobe bus of the load/store initiator.
// Signals :
//   req_valid/req_ready      core request handshake
//   req_we/addr/wdata/funct3 request payload (RV32 size/sign in funct3)
//   resp_valid/resp_ready    response handshake
//   resp_rdata/resp_err      response payload
//   mem_request/mem_we_re    memory strobe and direction
//   mem_address/mask/data_in memory word address, byte lanes, write data
//   mem_data_out             memory read data (1-cycle registered latency)
// Modports: master = the LSU, slave = core pipeline + memory environment.
// -----------------------------------------------------------------------------
interface lsu_mem_master_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_request;
    logic              mem_we_re;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_data_out;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready,
        input  resp_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        input  mem_data_out
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready,
        output resp_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_request, mem_we_re, mem_address, mem_data_in, mem_mask,
        output mem_data_out
    );
endinterface

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Purpose : Load/store initiator between the execute stage and the
//           single-port, word-addressed, byte-masked data memory. One RV32
//           load/store per handshake; stores are lane-replicated, loads are
//           extracted and sign/zero-extended after the 1-cycle read latency.
// Ports   :
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - lsu_mem_master_if.master (request, response and memory signals)
// Params  : ADDR_W - memory word-address width (req_addr[ADDR_W+1:2]).
// Config  : LSU_MISALIGN_CHECK_EN - when defined, misaligned H/W requests
//           return resp_err without touching memory; when undefined the
//           offset is forced to natural alignment and the access proceeds.
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Output and request-context registers
    logic              req_ready_q,   req_ready_d;
    logic              resp_valid_q,  resp_valid_d;
    logic [31:0]       resp_rdata_q,  resp_rdata_d;
    logic              resp_err_q,    resp_err_d;
    logic              mem_request_q, mem_request_d;
    logic              mem_we_re_q,   mem_we_re_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_data_in_q, mem_data_in_d;
    logic [3:0]        mem_mask_q,    mem_mask_d;
    logic              we_q,          we_d;
    logic [2:0]        funct3_q,      funct3_d;
    logic [1:0]        off_q,         off_d;

    // Request decode, only consumed on the accept cycle
    logic        accept;
    logic        illegal;
    logic        req_err;
    logic [1:0]  off_raw;
    logic [1:0]  off_eff;
    logic [3:0]  mask_dec;
    logic [31:0] wdata_rep;

    // Load extraction from the registered memory read data
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    assign accept  = (state_q == S_IDLE) && bus.req_valid;
    assign off_raw = bus.req_addr[1:0];

    // Illegal funct3: loads reject 011/110/111, stores reject 011 and any funct3[2]
    always_comb begin
        illegal = 1'b0;
        if (bus.req_we) begin
            illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3 == 3'b110);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Misaligned accesses are reported; any that survive are already aligned
    logic misaligned;
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = off_raw[0];
            2'b10:   misaligned = (off_raw != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end
    assign req_err = illegal || misaligned;
    assign off_eff = off_raw;
`else
    // Misaligned accesses are silently forced to natural alignment
    assign req_err = illegal;
    always_comb begin
        off_eff = off_raw;
        case (bus.req_funct3[1:0])
            2'b01:   off_eff = {off_raw[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off_raw;
        endcase
    end
`endif

    // Byte-lane mask and lane-replicated write data
    always_comb begin
        mask_dec  = 4'b1111;
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                mask_dec  = 4'b0001 << off_eff;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mask_dec  = 4'b0011 << off_eff;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                mask_dec  = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend per funct3
    assign rd_shifted = bus.mem_data_out >> {off_q, 3'b000};

    always_comb begin
        rd_ext = rd_shifted;
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b100:  rd_ext = {24'd0,                rd_shifted[7:0]};
            3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  rd_ext = {16'd0,                rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    state_d = req_err ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:   state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the output registers, decoded from the
    // next state so every output is a flop with no path from req_*/resp_ready
    always_comb begin
        req_ready_d   = (state_d == S_IDLE);
        resp_valid_d  = (state_d == S_RESP);
        mem_request_d = (state_d == S_ACCESS);
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        mem_we_re_d   = mem_we_re_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_mask_d    = mem_mask_q;
        we_d          = we_q;
        funct3_d      = funct3_q;
        off_d         = off_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    off_d    = off_eff;
                    if (req_err) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        mem_we_re_d   = bus.req_we;
                        mem_address_d = bus.req_addr[ADDR_W+1:2];
                        mem_data_in_d = wdata_rep;
                        mem_mask_d    = mask_dec;
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'd0;
                end
            end
            S_WAIT: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = rd_ext;
            end
            default: ;
        endcase
    end

    // Output and context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_err_q    <= 1'b0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= 32'd0;
            mem_mask_q    <= 4'd0;
            we_q          <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
        end else begin
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_mask_q    <= mem_mask_d;
            we_q          <= we_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_request = mem_request_q;
    assign bus.mem_we_re   = mem_we_re_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_mask    = mem_mask_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Purpose : Directed bench for lsu_mem_master with a behavioural data memory,
//           a shadow-memory reference model and a response scoreboard.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    localparam int unsigned ADDR_W = 8;

    logic clk;
    logic rst;
    logic load_mem;

    lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int mreq_cnt = 0;

    logic [32:0] sb_q[$];
    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];

    logic              cap_req;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [3:0]        cap_mask;
    logic [31:0]       cap_data;

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'h8899AABB;
        if (i == 4) return 32'h11223344;
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Behavioural memory: registered read, byte-masked write
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.mem_request) begin
            if (bus.mem_we_re) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_mask[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
            end else begin
                bus.mem_data_out <= mem[bus.mem_address];
            end
        end
    end

    always @(posedge clk) if (bus.mem_request === 1'b1) mreq_cnt <= mreq_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model; stores update the shadow memory
    task automatic ref_model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] f3, output logic [31:0] d, output logic e);
        logic [1:0]  o;
        logic [1:0]  sz;
        logic [7:0]  widx;
        logic        bad;
        logic        mis;
        logic [31:0] w;
        logic [7:0]  b8;
        logic [15:0] h16;
        o    = addr[1:0];
        sz   = f3[1:0];
        widx = addr[9:2];
        bad  = we ? (f3[2] || sz == 2'b11) : (sz == 2'b11 || f3 == 3'b110);
        mis  = (sz == 2'b01 && o[0]) || (sz == 2'b10 && o != 2'b00);
`ifdef LSU_MISALIGN_CHECK_EN
        e = bad || mis;
`else
        e = bad;
        if (mis && sz == 2'b01) o[0] = 1'b0;
        if (mis && sz == 2'b10) o = 2'b00;
`endif
        d = 32'd0;
        if (e) return;
        w = shadow[widx];
        if (we) begin
            case (sz)
                2'b00:   w[8*o +: 8]  = wd[7:0];
                2'b01:   w[8*o +: 16] = wd[15:0];
                default: w = wd;
            endcase
            shadow[widx] = w;
        end else begin
            b8  = w[8*o +: 8];
            h16 = w[8*o +: 16];
            case (f3)
                3'b000:  d = 32'($signed(b8));
                3'b100:  d = 32'(b8);
                3'b001:  d = 32'($signed(h16));
                3'b101:  d = 32'(h16);
                default: d = w;
            endcase
        end
    endtask

    // One request/response transaction with latency, strobe and scoreboard checks
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold, input string tag);
        logic [31:0] exp_data;
        logic        exp_err;
        logic [32:0] ent;
        int exp_lat, lat, wait_n, mreq0;
        ref_model(we, addr, wd, f3, exp_data, exp_err);
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        wait_n = 0;
        while (bus.req_ready !== 1'b1 && wait_n < 20) begin
            @(posedge clk); #1; wait_n++;
        end
        chk({tag, "/req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        sb_q.push_back({exp_err, exp_data});
        mreq0 = mreq_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        cap_req  = bus.mem_request;
        cap_we   = bus.mem_we_re;
        cap_addr = bus.mem_address;
        cap_mask = bus.mem_mask;
        cap_data = bus.mem_data_in;
        chk({tag, "/mem_request_c1"}, 32'(cap_req), 32'(!exp_err));
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            chk({tag, "/sb_empty"}, 32'(sb_q.size()), 32'd1);
            ent = '0;
        end else begin
            ent = sb_q.pop_front();
        end
        for (int h = 0; h < hold; h++) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'b0;
            bus.req_addr   = 32'h0000_0000;
            bus.req_funct3 = 3'b010;
            chk({tag, "/hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, bus.resp_rdata, ent[31:0]);
            chk({tag, "/hold_err"},   32'(bus.resp_err), 32'(ent[32]));
            chk({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk({tag, "/rdata"}, bus.resp_rdata, ent[31:0]);
        chk({tag, "/err"},   32'(bus.resp_err), 32'(ent[32]));
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({tag, "/post_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "/post_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "/mem_strobes"}, 32'(mreq_cnt - mreq0), 32'(!exp_err));
    endtask

    task automatic chk_mem(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        chk({tag, "/mem_we_re"},   32'(cap_we),   32'(we));
        chk({tag, "/mem_address"}, 32'(cap_addr), 32'(a));
        chk({tag, "/mem_mask"},    32'(cap_mask), 32'(m));
        if (we) chk({tag, "/mem_data_in"}, cap_data, d);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        rst            = 1'b1;
        load_mem       = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_funct3 = 3'd0;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        load_mem = 1'b0;

        // Reset values
        chk("rst/req_ready",   32'(bus.req_ready),   32'd1);
        chk("rst/resp_valid",  32'(bus.resp_valid),  32'd0);
        chk("rst/resp_rdata",  bus.resp_rdata,       32'd0);
        chk("rst/resp_err",    32'(bus.resp_err),    32'd0);
        chk("rst/mem_request", 32'(bus.mem_request), 32'd0);
        chk("rst/mem_we_re",   32'(bus.mem_we_re),   32'd0);
        chk("rst/mem_address", 32'(bus.mem_address), 32'd0);
        chk("rst/mem_data_in", bus.mem_data_in,      32'd0);
        chk("rst/mem_mask",    32'(bus.mem_mask),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Word load
        xact(1'b0, 32'h0C, 32'd0, 3'b010, 0, "lw_0c");
        chk("lw_0c/cap_req", 32'(cap_req), 32'd1);
        chk_mem("lw_0c", 1'b0, 8'd3, 4'b1111, 32'd0);
        chk("lw_0c/exp_const", shadow[3], 32'h8899AABB);

        // Byte/half loads with sign and zero extension
        xact(1'b0, 32'h0D, 32'd0, 3'b000, 0, "lb_0d");
        chk_mem("lb_0d", 1'b0, 8'd3, 4'b0010, 32'd0);
        xact(1'b0, 32'h0D, 32'd0, 3'b100, 0, "lbu_0d");
        xact(1'b0, 32'h0E, 32'd0, 3'b001, 0, "lh_0e");
        chk_mem("lh_0e", 1'b0, 8'd3, 4'b1100, 32'd0);
        xact(1'b0, 32'h0E, 32'd0, 3'b101, 0, "lhu_0e");

        // Byte store with replication, read back
        xact(1'b1, 32'h11, 32'h0000_00CD, 3'b000, 0, "sb_11");
        chk_mem("sb_11", 1'b1, 8'd4, 4'b0010, 32'hCDCDCDCD);
        xact(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_10");

        // Misaligned half store
        xact(1'b1, 32'h13, 32'h0000_BEEF, 3'b001, 0, "sh_13");
`ifndef LSU_MISALIGN_CHECK_EN
        chk_mem("sh_13", 1'b1, 8'd4, 4'b1100, 32'hBEEFBEEF);
`endif
        xact(1'b0, 32'h10, 32'd0, 3'b010, 0, "lw_10b");

        // Illegal funct3 and misaligned load
        xact(1'b0, 32'h0C, 32'd0, 3'b011, 0, "ld_f3_011");
        xact(1'b0, 32'h0C, 32'd0, 3'b110, 0, "ld_f3_110");
        xact(1'b1, 32'h20, 32'h1234_5678, 3'b100, 0, "st_f3_100");
        xact(1'b0, 32'h0D, 32'd0, 3'b001, 0, "lh_0d_mis");

        // Word store / read back, then a half store at a high lane
        xact(1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010, 0, "sw_20");
        chk_mem("sw_20", 1'b1, 8'd8, 4'b1111, 32'hDEADBEEF);
        xact(1'b1, 32'h22, 32'h0000_7A55, 3'b001, 0, "sh_22");
        xact(1'b0, 32'h20, 32'd0, 3'b010, 0, "lw_20");
        xact(1'b0, 32'h23, 32'd0, 3'b000, 0, "lb_23");

        // Response back-pressure: 4 cycles with resp_ready low
        xact(1'b0, 32'h0C, 32'd0, 3'b010, 4, "lw_hold");

        // Reset during WAIT
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h14;
        bus.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_wait/pre_ready", 32'(bus.req_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait/mem_request", 32'(bus.mem_request), 32'd0);
        chk("rst_wait/resp_valid",  32'(bus.resp_valid),  32'd0);
        chk("rst_wait/req_ready",   32'(bus.req_ready),   32'd1);
        chk("rst_wait/mem_address", 32'(bus.mem_address), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1'b0, 32'h0C, 32'd0, 3'b010, 0, "lw_after_rst");

        // Reset during ACCESS of a store: the write must not land
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_addr   = 32'h18;
        bus.req_wdata  = 32'hFFFF_FFFF;
        bus.req_funct3 = 3'b010;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_access/mem_request", 32'(bus.mem_request), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(1'b0, 32'h18, 32'd0, 3'b010, 0, "lw_18_unwritten");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
